// File: rtl/v16_peak_detector_pkg.sv
// Shared v16 chain packages: sample sizing, detector defaults and the types the
// detector and the readout stage both use.
package package_settings;
  localparam int SIZE_FILTER_DATA = 15;
endpackage

package v16_parameters;
  import package_settings::*;

  localparam int V16_THRESHOLD     = 100;
  localparam int V16_DEAD_TIME     = 16;
  localparam int V16_MAX_PULSE_LEN = 64;
  localparam int V16_TS_WIDTH      = 32;
  localparam int V16_CNT_WIDTH     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DEAD  = 2'd2
  } peak_state_t;

  // "time" is a keyword, hence peak_time for the timestamp field.
  typedef struct packed {
    logic signed [SIZE_FILTER_DATA:0] amplitude;
    logic [V16_TS_WIDTH-1:0]          peak_time;
    logic                             pileup;
  } peak_event_t;
endpackage

// File: rtl/v16_peak_detector_if.sv
// Sample-in / event-out bundle between the v16 filter, the peak detector and readout.
interface v16_peak_detector_if #(
  parameter int TS_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
);
  import package_settings::*;

  logic signed [SIZE_FILTER_DATA:0] filter_data;
  logic signed [SIZE_FILTER_DATA:0] peak_amplitude;
  logic [TS_WIDTH-1:0]              peak_time;
  logic                             peak_valid;
  logic                             pileup;
  logic                             busy;
  logic [CNT_WIDTH-1:0]             event_count;

  modport master (
    output filter_data,
    input  peak_amplitude, peak_time, peak_valid, pileup, busy, event_count
  );

  modport slave (
    input  filter_data,
    output peak_amplitude, peak_time, peak_valid, pileup, busy, event_count
  );
endinterface

// File: rtl/v16_timestamp_counter.sv
// Free-running wrapping timestamp; value N is the stamp of the sample taken at that edge.
module v16_timestamp_counter #(
  parameter int TS_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  output logic [TS_WIDTH-1:0] o_ts
);
  logic [TS_WIDTH-1:0] r_ts;

  always_ff @(posedge clk) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + 1'b1;
  end

  assign o_ts = r_ts;
endmodule

// File: rtl/v16_peak_detector.sv
// Pulse peak detector: arms on a threshold crossing, tracks the pulse maximum and its
// timestamp, emits one event per pulse, then holds off for a dead time.
module v16_peak_detector
  import package_settings::*, v16_parameters::*;
#(
  parameter int THRESHOLD     = V16_THRESHOLD,
  parameter int DEAD_TIME     = V16_DEAD_TIME,
  parameter int MAX_PULSE_LEN = V16_MAX_PULSE_LEN,
  parameter int TS_WIDTH      = V16_TS_WIDTH,
  parameter int CNT_WIDTH     = V16_CNT_WIDTH
) (
  input logic                clk,
  input logic                reset,
  v16_peak_detector_if.slave bus
);
  localparam int DW     = SIZE_FILTER_DATA + 1;
  localparam int LEN_W  = $clog2(MAX_PULSE_LEN + 1);
  localparam int DEAD_W = $clog2(DEAD_TIME + 1);
  localparam logic signed [DW-1:0] TH = DW'(THRESHOLD);

  peak_state_t          r_state, w_state_nxt;
  logic signed [DW-1:0] w_sample, r_max, w_max_nxt, r_amp;
  logic [TS_WIDTH-1:0]  w_ts, r_max_t, w_max_t_nxt, r_time;
  logic [LEN_W-1:0]     r_len, w_len_nxt;
  logic [DEAD_W-1:0]    r_dead;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_above, w_emit, w_pile;
  logic                 r_valid, r_pile, r_busy;

  v16_timestamp_counter #(.TS_WIDTH(TS_WIDTH)) u_ts (
    .clk   (clk),
    .reset (reset),
    .o_ts  (w_ts)
  );

  assign w_sample = bus.filter_data;
  assign w_above  = w_sample > TH;

  always_comb begin
    w_state_nxt = r_state;
    w_max_nxt   = r_max;
    w_max_t_nxt = r_max_t;
    w_len_nxt   = r_len;
    w_emit      = 1'b0;
    w_pile      = 1'b0;
    case (r_state)
      IDLE, ARMED: begin
        if (w_above) begin
          // strict '>' keeps the earliest timestamp on a plateau
          if (r_state == IDLE || w_sample > r_max) begin
            w_max_nxt   = w_sample;
            w_max_t_nxt = w_ts;
          end
          w_len_nxt   = (r_state == IDLE) ? LEN_W'(1) : r_len + 1'b1;
          w_state_nxt = ARMED;
          if (w_len_nxt == LEN_W'(MAX_PULSE_LEN)) begin
            w_emit      = 1'b1;
            w_pile      = 1'b1;
            w_state_nxt = DEAD;
          end
        end else if (r_state == ARMED) begin
          w_emit      = 1'b1;
          w_state_nxt = DEAD;
        end
      end
      DEAD:    if (r_dead == '0 && !w_above) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_max   <= '0;
      r_max_t <= '0;
      r_len   <= '0;
      r_dead  <= '0;
      r_valid <= 1'b0;
      r_amp   <= '0;
      r_time  <= '0;
      r_pile  <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_max   <= w_max_nxt;
      r_max_t <= w_max_t_nxt;
      r_len   <= w_len_nxt;
      r_valid <= w_emit;
      if (w_emit)            r_dead <= DEAD_W'(DEAD_TIME);
      else if (r_dead != '0) r_dead <= r_dead - 1'b1;
      if (w_emit) begin
        r_amp  <= w_max_nxt;
        r_time <= w_max_t_nxt;
        r_pile <= w_pile;
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.peak_valid     = r_valid;
  assign bus.peak_amplitude = r_amp;
  assign bus.peak_time      = r_time;
  assign bus.pileup         = r_pile;
  assign bus.busy           = r_busy;
  assign bus.event_count    = r_cnt;
endmodule

// File: tb/tb_v16_peak_detector.sv
// Bench for v16_peak_detector: directed table, hand sequences and random segments,
// all checked every cycle against a pulse-scanning reference model.
module tb_v16_peak_detector;
  import package_settings::*;

  localparam int DW   = SIZE_FILTER_DATA + 1;
  localparam int TH   = 100;
  localparam int MAXN = 512;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic signed [DW-1:0] din = '0;
  always #5 clk = ~clk;

  v16_peak_detector_if #(.TS_WIDTH(32), .CNT_WIDTH(16)) bus0();
  v16_peak_detector_if #(.TS_WIDTH(8),  .CNT_WIDTH(2))  bus1();
  assign bus0.filter_data = din;
  assign bus1.filter_data = din;

  v16_peak_detector #(.THRESHOLD(TH), .DEAD_TIME(16), .MAX_PULSE_LEN(64),
                      .TS_WIDTH(32), .CNT_WIDTH(16))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));

  // corner instance: single-sample pile-ups, 1-cycle dead time, narrow wrapping counters
  v16_peak_detector #(.THRESHOLD(TH), .DEAD_TIME(1), .MAX_PULSE_LEN(1),
                      .TS_WIDTH(8), .CNT_WIDTH(2))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct {
    bit     v;
    int     amp;
    longint tm;
    bit     pl;
    bit     bsy;
    int     cnt;
  } exp_t;

  typedef struct {
    int start;
    int nv;
    int v[8];
    int amp;
    int tm;
    bit pl;
    int eidx;
  } vec_t;

  int   smp [MAXN];
  int   seg_n;
  exp_t ex  [2][MAXN];
  int   n_chk = 0, n_fail = 0;
  int   dev_n;
  int   dev_amp[4], dev_tm[4], dev_pl[4], dev_idx[4];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: scan the recorded segment for pulses, place each event at its deciding
  // sample, then derive held outputs, saturating count and busy windows.
  task automatic model(input int k, input int dead, input int maxlen, input int tsw,
                       input int cmax);
    bit evf[MAXN];
    bit bsy[MAXN];
    int eamp[MAXN], etm[MAXN];
    bit epl[MAXN];
    int i, j, e, kk, mx, mt, amp, cnt;
    bit p, pl;
    longint tm;
    for (int c = 0; c < MAXN; c++) begin
      evf[c] = 0; bsy[c] = 0; eamp[c] = 0; etm[c] = 0; epl[c] = 0;
    end
    i = 0;
    while (i < seg_n) begin
      if (smp[i] <= TH) begin
        i++;
      end else begin
        j = i; mx = smp[i]; mt = i;
        while (j < seg_n && smp[j] > TH && (j - i) < maxlen) begin
          if (smp[j] > mx) begin mx = smp[j]; mt = j; end
          j++;
        end
        if (j - i == maxlen) begin e = j - 1; pl = 1; end
        else if (j < seg_n)  begin e = j;     pl = 0; end
        else begin
          for (int c = i; c < seg_n; c++) bsy[c] = 1;
          break;
        end
        evf[e] = 1; eamp[e] = mx; etm[e] = mt; epl[e] = pl;
        kk = e + dead + 1;
        while (kk < seg_n && smp[kk] > TH) kk++;
        for (int c = i; c < kk && c < seg_n; c++) bsy[c] = 1;
        i = kk + 1;
      end
    end
    amp = 0; tm = 0; p = 0; cnt = 0;
    for (int c = 0; c < seg_n; c++) begin
      if (evf[c]) begin
        amp = eamp[c];
        tm  = longint'(etm[c]) % (longint'(1) << tsw);
        p   = epl[c];
        if (cnt < cmax) cnt++;
      end
      ex[k][c] = '{evf[c], amp, tm, p, bsy[c], cnt};
    end
  endtask

  task automatic run_seg(input int rcyc);
    din = '0;
    reset = 1'b1;
    repeat (rcyc) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst0_valid", bus0.peak_valid, 0);
    chk("rst0_amp",   int'($signed(bus0.peak_amplitude)), 0);
    chk("rst0_time",  bus0.peak_time, 0);
    chk("rst0_pile",  bus0.pileup, 0);
    chk("rst0_busy",  bus0.busy, 0);
    chk("rst0_cnt",   bus0.event_count, 0);
    chk("rst1_busy",  bus1.busy, 0);
    chk("rst1_cnt",   bus1.event_count, 0);
    model(0, 16, 64, 32, 65535);
    model(1, 1, 1, 8, 3);
    dev_n = 0;
    for (int c = 0; c < seg_n; c++) begin
      din = smp[c][DW-1:0];
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("d0_valid@%0d", c), bus0.peak_valid, ex[0][c].v);
      chk($sformatf("d0_amp@%0d", c),   int'($signed(bus0.peak_amplitude)), ex[0][c].amp);
      chk($sformatf("d0_time@%0d", c),  bus0.peak_time, ex[0][c].tm);
      chk($sformatf("d0_pile@%0d", c),  bus0.pileup, ex[0][c].pl);
      chk($sformatf("d0_busy@%0d", c),  bus0.busy, ex[0][c].bsy);
      chk($sformatf("d0_cnt@%0d", c),   bus0.event_count, ex[0][c].cnt);
      chk($sformatf("d1_valid@%0d", c), bus1.peak_valid, ex[1][c].v);
      chk($sformatf("d1_amp@%0d", c),   int'($signed(bus1.peak_amplitude)), ex[1][c].amp);
      chk($sformatf("d1_time@%0d", c),  bus1.peak_time, ex[1][c].tm);
      chk($sformatf("d1_pile@%0d", c),  bus1.pileup, ex[1][c].pl);
      chk($sformatf("d1_busy@%0d", c),  bus1.busy, ex[1][c].bsy);
      chk($sformatf("d1_cnt@%0d", c),   bus1.event_count, ex[1][c].cnt);
      if (bus0.peak_valid && dev_n < 4) begin
        dev_amp[dev_n] = int'($signed(bus0.peak_amplitude));
        dev_tm[dev_n]  = int'(bus0.peak_time);
        dev_pl[dev_n]  = int'(bus0.pileup);
        dev_idx[dev_n] = c;
        dev_n++;
      end
    end
  endtask

  task automatic clear_seg(input int n);
    seg_n = n;
    for (int c = 0; c < MAXN; c++) smp[c] = 0;
  endtask

  vec_t tbl[5];
  bit   hi;

  initial begin
    tbl[0] = '{10, 7, '{50, 150, 300, 500, 300, 150, 50, 0}, 500, 13, 1'b0, 16};
    tbl[1] = '{20, 6, '{200, 400, 400, 400, 90, 0, 0, 0},    400, 21, 1'b0, 24};
    tbl[2] = '{5,  3, '{100, 101, 100, 0, 0, 0, 0, 0},       101, 6,  1'b0, 7};
    tbl[3] = '{3,  4, '{-2048, -2048, 120, 0, 0, 0, 0, 0},   120, 5,  1'b0, 6};
    tbl[4] = '{8,  3, '{150, 250, 100, 0, 0, 0, 0, 0},       250, 9,  1'b0, 10};

    // quiet baseline
    clear_seg(200);
    run_seg(3);
    chk("quiet_nev", dev_n, 0);

    // reset during the rising edge of a triangle: discarded, no event
    clear_seg(12);
    smp[10] = 50; smp[11] = 150;
    run_seg(1);
    chk("midrst_nev", dev_n, 0);

    // directed single pulses; timestamps restart after every reset
    for (int t = 0; t < 5; t++) begin
      clear_seg(40);
      for (int q = 0; q < tbl[t].nv; q++) smp[tbl[t].start + q] = tbl[t].v[q];
      run_seg(1);
      chk($sformatf("tbl%0d_nev", t),  dev_n, 1);
      chk($sformatf("tbl%0d_idx", t),  dev_idx[0], tbl[t].eidx);
      chk($sformatf("tbl%0d_amp", t),  dev_amp[0], tbl[t].amp);
      chk($sformatf("tbl%0d_time", t), dev_tm[0], tbl[t].tm);
      chk($sformatf("tbl%0d_pile", t), dev_pl[0], tbl[t].pl);
    end

    // pile-up on a stuck baseline, then a clean pulse once the input drops
    clear_seg(200);
    for (int c = 20; c < 170; c++) smp[c] = 200;
    smp[175] = 200; smp[176] = 300; smp[177] = 200;
    run_seg(1);
    chk("pile_nev",   dev_n, 2);
    chk("pile_idx0",  dev_idx[0], 83);
    chk("pile_amp0",  dev_amp[0], 200);
    chk("pile_time0", dev_tm[0], 20);
    chk("pile_pile0", dev_pl[0], 1);
    chk("pile_idx1",  dev_idx[1], 178);
    chk("pile_amp1",  dev_amp[1], 300);
    chk("pile_time1", dev_tm[1], 176);
    chk("pile_pile1", dev_pl[1], 0);

    // dead time swallows a pulse, high input holds DEAD past expiry, -2048 never triggers
    clear_seg(80);
    smp[37] = 200; smp[38] = 500; smp[39] = 300;
    for (int c = 45; c <= 60; c++) smp[c] = 700;
    smp[63] = 300;
    for (int c = 70; c <= 75; c++) smp[c] = -2048;
    run_seg(1);
    chk("dead_nev",   dev_n, 2);
    chk("dead_idx0",  dev_idx[0], 40);
    chk("dead_amp0",  dev_amp[0], 500);
    chk("dead_time0", dev_tm[0], 38);
    chk("dead_idx1",  dev_idx[1], 64);
    chk("dead_amp1",  dev_amp[1], 300);
    chk("dead_time1", dev_tm[1], 63);

    // random bursty segments, long enough to wrap the 8-bit timestamp
    for (int s = 0; s < 4; s++) begin
      clear_seg(400);
      hi = 0;
      for (int c = 0; c < seg_n; c++) begin
        if ($urandom_range(0, 99) < (hi ? 3 : 10)) hi = ~hi;
        smp[c] = hi ? int'($urandom_range(101, 1500))
                    : int'($urandom_range(0, 300)) - 200;
      end
      run_seg(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
